// File: rtl/dma_desc_ring.sv
// Multi-channel DMA descriptor store with per-channel ring sequencing.
// The host writes {page addr, length} descriptors into disabled channels. Each enabled channel
// prefetches the descriptor at its ring index, holds it valid until the DMA engine advances, and
// then steps to the next index, wrapping after ch_last.
module dma_desc_ring #(
  parameter int unsigned DMA_BUFFS_BITS = 5,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned ADDR_HI_BITS   = 20,
  parameter int unsigned LEN_BITS       = 12,
  localparam int unsigned CH_BITS       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                               s_ul_clk,
  input  logic                               rst,
  input  logic [CH_BITS+DMA_BUFFS_BITS-1:0]  s_ul_waddr,
  input  logic [31:0]                        s_ul_wdata,
  input  logic                               s_ul_wvalid,
  output logic                               wr_drop,
  input  logic [CHANNELS-1:0]                ch_en,
  input  logic [CHANNELS*DMA_BUFFS_BITS-1:0] ch_last,
  input  logic [CHANNELS-1:0]                ch_advance,
  output logic [CHANNELS-1:0]                ch_valid,
  output logic [CHANNELS*DMA_BUFFS_BITS-1:0] ch_bufno,
  output logic [CHANNELS*ADDR_HI_BITS-1:0]   ch_addr,
  output logic [CHANNELS*LEN_BITS-1:0]       ch_len
);

  localparam int unsigned DW    = ADDR_HI_BITS + LEN_BITS;
  localparam int unsigned AW    = CH_BITS + DMA_BUFFS_BITS;
  localparam int unsigned Depth = CHANNELS << DMA_BUFFS_BITS;

  typedef logic [DMA_BUFFS_BITS-1:0] idx_t;
  typedef logic [CH_BITS-1:0]        ch_t;

  // Descriptor RAM and its registered read port
  logic [DW-1:0] mem [Depth];
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] rd_addr;
  logic          rd_vld_q;
  ch_t           rd_ch_q;

  // Per-channel state
  logic [CHANNELS-1:0]     valid_q, valid_d;
  logic [CHANNELS-1:0]     pend_q, pend_d;
  idx_t                    bufno_q [CHANNELS];
  idx_t                    bufno_d [CHANNELS];
  logic [ADDR_HI_BITS-1:0] addr_q  [CHANNELS];
  logic [ADDR_HI_BITS-1:0] addr_d  [CHANNELS];
  logic [LEN_BITS-1:0]     len_q   [CHANNELS];
  logic [LEN_BITS-1:0]     len_d   [CHANNELS];
  idx_t                    last_c;

  // Arbiter
  logic [CHANNELS-1:0] need;
  logic                grant;
  ch_t                 grant_ch;
  ch_t                 cand;
  ch_t                 last_q, last_d;

  // Write decode
  ch_t  wr_ch;
  logic wr_in_range;
  logic wr_hit_en;
  logic wr_accept;
  logic wr_drop_d, wr_drop_q;

  // Decode host writes: accept into disabled channels, flag writes to enabled ones
  always_comb begin
    wr_ch       = s_ul_waddr[AW-1:DMA_BUFFS_BITS];
    wr_in_range = 32'(wr_ch) < CHANNELS;
    wr_hit_en   = wr_in_range && ch_en[wr_ch];
    wr_accept   = s_ul_wvalid && wr_in_range && !wr_hit_en;
    wr_drop_d   = s_ul_wvalid && wr_hit_en;
  end

  // Round-robin pick of one channel needing a fetch, searching after the last grant
  always_comb begin
    need     = ch_en & ~valid_q & ~pend_q;
    grant    = 1'b0;
    grant_ch = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      cand = ch_t'((32'(last_q) + i) % CHANNELS);
      if (!grant && need[cand]) begin
        grant    = 1'b1;
        grant_ch = cand;
      end
    end
    rd_addr = {grant_ch, bufno_q[grant_ch]};
    last_d  = grant ? grant_ch : last_q;
  end

  // RAM write port and registered read port; contents are not reset
  always_ff @(posedge s_ul_clk) begin
    if (wr_accept) begin
      mem[s_ul_waddr] <= s_ul_wdata[DW-1:0];
    end
    if (grant) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Per-channel next state: disable, fetch return, fetch issue, advance
  always_comb begin
    valid_d = valid_q;
    pend_d  = pend_q;
    bufno_d = bufno_q;
    addr_d  = addr_q;
    len_d   = len_q;
    last_c  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      last_c = ch_last[c*DMA_BUFFS_BITS +: DMA_BUFFS_BITS];
      if (!ch_en[c]) begin
        // Clearing pend here is what discards a read already in flight
        valid_d[c] = 1'b0;
        pend_d[c]  = 1'b0;
        bufno_d[c] = '0;
      end else begin
        if (rd_vld_q && (rd_ch_q == ch_t'(c)) && pend_q[c]) begin
          valid_d[c] = 1'b1;
          pend_d[c]  = 1'b0;
          addr_d[c]  = rd_data_q[DW-1:LEN_BITS];
          len_d[c]   = rd_data_q[LEN_BITS-1:0];
        end else if (grant && (grant_ch == ch_t'(c))) begin
          pend_d[c] = 1'b1;
        end
        // Advance on an invalid descriptor is ignored; >= also recovers from a shrunk ch_last
        if (ch_advance[c] && valid_q[c]) begin
          valid_d[c] = 1'b0;
          bufno_d[c] = (bufno_q[c] >= last_c) ? '0 : bufno_q[c] + idx_t'(1);
        end
      end
    end
  end

  // State registers; arbiter pointer resets so channel 0 is served first
  always_ff @(posedge s_ul_clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      pend_q    <= '0;
      bufno_q   <= '{default: '0};
      addr_q    <= '{default: '0};
      len_q     <= '{default: '0};
      last_q    <= ch_t'(CHANNELS - 1);
      rd_vld_q  <= 1'b0;
      rd_ch_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      bufno_q   <= bufno_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      last_q    <= last_d;
      rd_vld_q  <= grant;
      rd_ch_q   <= grant_ch;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Flatten per-channel registers onto the output buses
  always_comb begin
    ch_valid = valid_q;
    wr_drop  = wr_drop_q;
    ch_bufno = '0;
    ch_addr  = '0;
    ch_len   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_bufno[c*DMA_BUFFS_BITS +: DMA_BUFFS_BITS] = bufno_q[c];
      ch_addr[c*ADDR_HI_BITS +: ADDR_HI_BITS]      = addr_q[c];
      ch_len[c*LEN_BITS +: LEN_BITS]               = len_q[c];
    end
  end

endmodule

// File: tb/tb_dma_desc_ring.sv
// Bench for dma_desc_ring: directed ring scenarios followed by random traffic, all outputs
// compared every cycle against a per-edge behavioural model of the descriptor rings.
module tb_dma_desc_ring;

  localparam int B  = 5;
  localparam int C  = 2;
  localparam int AH = 20;
  localparam int LB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [B:0]    waddr;
  logic [31:0]   wdata;
  logic          wvalid;
  logic          wr_drop;
  logic [C-1:0]  en;
  logic [C*B-1:0] last;
  logic [C-1:0]  adv;
  logic [C-1:0]  valid;
  logic [C*B-1:0] bufno;
  logic [C*AH-1:0] addr;
  logic [C*LB-1:0] len;

  always #5 clk = ~clk;

  dma_desc_ring #(
    .DMA_BUFFS_BITS(B),
    .CHANNELS      (C),
    .ADDR_HI_BITS  (AH),
    .LEN_BITS      (LB)
  ) dut (
    .s_ul_clk   (clk),
    .rst        (rst),
    .s_ul_waddr (waddr),
    .s_ul_wdata (wdata),
    .s_ul_wvalid(wvalid),
    .wr_drop    (wr_drop),
    .ch_en      (en),
    .ch_last    (last),
    .ch_advance (adv),
    .ch_valid   (valid),
    .ch_bufno   (bufno),
    .ch_addr    (addr),
    .ch_len     (len)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mmem [C][32];
  bit          m_valid [C];
  int          m_bufno [C];
  bit          m_fly   [C];
  logic [31:0] m_snap  [C];
  logic [31:0] m_desc  [C];
  bit          m_drop;
  int          m_ptr;

  logic [19:0] ta [4] = '{20'h12345, 20'h23456, 20'h34567, 20'h45678};
  logic [11:0] tl [4] = '{12'h010, 12'h020, 12'h030, 12'h040};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      m_valid[c] = 1'b0;
      m_bufno[c] = 0;
      m_fly[c]   = 1'b0;
      m_desc[c]  = '0;
    end
    m_drop = 1'b0;
    m_ptr  = C - 1;
  endtask

  task automatic check_all(input string pfx);
    for (int c = 0; c < C; c++) begin
      check($sformatf("%s ch%0d valid", pfx, c), 32'(valid[c]), 32'(m_valid[c]));
      check($sformatf("%s ch%0d bufno", pfx, c), 32'(bufno[c*B +: B]), 32'(m_bufno[c]));
      if (m_valid[c]) begin
        check($sformatf("%s ch%0d addr", pfx, c), 32'(addr[c*AH +: AH]), 32'(m_desc[c][31:12]));
        check($sformatf("%s ch%0d len", pfx, c), 32'(len[c*LB +: LB]), 32'(m_desc[c][11:0]));
      end
    end
    check($sformatf("%s wr_drop", pfx), 32'(wr_drop), 32'(m_drop));
  endtask

  // Advance the model by one clock edge using the inputs held now, then clock and compare
  task automatic step();
    bit pv [C];
    bit pf [C];
    int g;
    int wc;
    int wi;
    int lc;
    pv = m_valid;
    pf = m_fly;
    if (rst) begin
      model_reset();
    end else begin
      m_drop = 1'b0;
      if (wvalid) begin
        wc = int'(waddr[B]);
        wi = int'(waddr[B-1:0]);
        if (wc < C) begin
          if (en[wc]) m_drop = 1'b1;
          else mmem[wc][wi] = wdata;
        end
      end
      g = -1;
      for (int k = 1; k <= C; k++) begin
        if (g < 0 && en[(m_ptr + k) % C] && !pv[(m_ptr + k) % C] && !pf[(m_ptr + k) % C])
          g = (m_ptr + k) % C;
      end
      for (int c = 0; c < C; c++) begin
        if (!en[c]) begin
          m_valid[c] = 1'b0;
          m_fly[c]   = 1'b0;
          m_bufno[c] = 0;
        end else begin
          if (pf[c]) begin
            m_valid[c] = 1'b1;
            m_desc[c]  = m_snap[c];
            m_fly[c]   = 1'b0;
          end
          if (adv[c] && pv[c]) begin
            lc         = int'(last[c*B +: B]);
            m_valid[c] = 1'b0;
            m_bufno[c] = (m_bufno[c] >= lc) ? 0 : m_bufno[c] + 1;
          end
        end
      end
      if (g >= 0) begin
        m_snap[g] = mmem[g][m_bufno[g]];
        m_fly[g]  = 1'b1;
        m_ptr     = g;
      end
    end
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic bus_write(input int ch, input int idx, input logic [31:0] d);
    waddr  = (B+1)'(ch * 32 + idx);
    wdata  = d;
    wvalid = 1'b1;
    step();
    wvalid = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    waddr  = '0;
    wdata  = '0;
    wvalid = 1'b0;
    en     = '0;
    last   = '0;
    adv    = '0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("reset valid", 32'(valid), 32'h0);
    check("reset bufno", 32'(bufno), 32'h0);
    check("reset addr0", 32'(addr[19:0]), 32'h0);
    check("reset addr1", 32'(addr[39:20]), 32'h0);
    check("reset len", 32'(len), 32'h0);
    check("reset wr_drop", 32'(wr_drop), 32'h0);
    step();
    step();
    rst = 1'b0;

    // Fill every descriptor so nothing fetched later is undefined
    for (int ch = 0; ch < C; ch++)
      for (int i = 0; i < 32; i++) bus_write(ch, i, $urandom());
    for (int i = 0; i < 4; i++) bus_write(0, i, {ta[i], tl[i]});
    last[4:0] = 5'd3;
    last[9:5] = 5'd3;

    // Enable: valid on the 2nd edge with index 0
    en[0] = 1'b1;
    step();
    check("t1 edge1 valid", 32'(valid[0]), 32'h0);
    step();
    check("t1 edge2 valid", 32'(valid[0]), 32'h1);
    check("t1 addr", 32'(addr[19:0]), 32'h12345);
    check("t1 len", 32'(len[11:0]), 32'h010);
    check("t1 bufno", 32'(bufno[4:0]), 32'h0);

    // Four advances walk 1,2,3 and wrap to 0
    for (int k = 1; k <= 4; k++) begin
      adv[0] = 1'b1;
      step();
      adv[0] = 1'b0;
      check("t2 bufno", 32'(bufno[4:0]), 32'(k % 4));
      check("t2 adv edge valid", 32'(valid[0]), 32'h0);
      step();
      check("t2 refetch edge1", 32'(valid[0]), 32'h0);
      step();
      check("t2 refetch edge2", 32'(valid[0]), 32'h1);
      check("t2 addr", 32'(addr[19:0]), 32'(ta[k % 4]));
      check("t2 len", 32'(len[11:0]), 32'(tl[k % 4]));
    end
    en = '0;
    step();

    // Both channels together; last grant was ch0, so ch1 goes first
    en = 2'b11;
    step();
    step();
    check("t3a edge2", 32'(valid), 32'h2);
    step();
    check("t3a edge3", 32'(valid), 32'h3);
    // Regrant ch1 so ch0 is favoured next
    adv[1] = 1'b1;
    step();
    adv[1] = 1'b0;
    step();
    step();
    check("t3 ch1 refetched", 32'(valid), 32'h3);
    en = '0;
    step();
    en = 2'b11;
    step();
    step();
    check("t3b edge2", 32'(valid), 32'h1);
    step();
    check("t3b edge3", 32'(valid), 32'h3);
    en = '0;
    step();

    // Write into an enabled channel is dropped and flagged for one cycle
    en = 2'b01;
    step();
    waddr  = {1'b0, 5'd1};
    wdata  = 32'hABCDE0FF;
    wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("t4 wr_drop pulse", 32'(wr_drop), 32'h1);
    step();
    check("t4 wr_drop clear", 32'(wr_drop), 32'h0);
    en = '0;
    step();
    en = 2'b01;
    step();
    step();
    adv[0] = 1'b1;
    step();
    adv[0] = 1'b0;
    step();
    step();
    check("t4 readback addr", 32'(addr[19:0]), 32'h23456);
    check("t4 readback len", 32'(len[11:0]), 32'h020);

    // Disable right after a grant, re-enable: stale return is discarded
    en = '0;
    step();
    en = 2'b01;
    step();
    en = 2'b00;
    step();
    check("t5 stale discarded", 32'(valid[0]), 32'h0);
    en = 2'b01;
    step();
    check("t5 refetch edge1", 32'(valid[0]), 32'h0);
    step();
    check("t5 refetch edge2", 32'(valid[0]), 32'h1);
    check("t5 bufno", 32'(bufno[4:0]), 32'h0);
    check("t5 addr", 32'(addr[19:0]), 32'h12345);

    // Reset in mid-ring
    for (int k = 0; k < 2; k++) begin
      adv[0] = 1'b1;
      step();
      adv[0] = 1'b0;
      step();
      step();
    end
    check("t6 pre bufno", 32'(bufno[4:0]), 32'h2);
    #3 rst = 1'b1;
    #1;
    check("t6 rst valid", 32'(valid), 32'h0);
    check("t6 rst bufno", 32'(bufno), 32'h0);
    check("t6 rst addr", 32'(addr[19:0]), 32'h0);
    check("t6 rst len", 32'(len[11:0]), 32'h0);
    model_reset();
    en = '0;
    step();
    rst = 1'b0;
    en  = 2'b01;
    step();
    check("t6 edge1", 32'(valid[0]), 32'h0);
    step();
    check("t6 edge2", 32'(valid[0]), 32'h1);
    check("t6 bufno", 32'(bufno[4:0]), 32'h0);
    check("t6 addr", 32'(addr[19:0]), 32'h12345);

    // Random traffic against the model
    repeat (3000) begin
      for (int c = 0; c < C; c++) begin
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
        adv[c] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 63) == 0) last[c*B +: B] = B'($urandom_range(0, 7));
      end
      wvalid = ($urandom_range(0, 3) == 0);
      waddr  = (B+1)'($urandom());
      wdata  = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
